debug_trace_ctl: RTL
====================

# debug_trace_ctl

Parametrised trace-and-breakpoint controller for the 8051 debug subsystem. It records one sample per qualified opcode fetch into an inferred DEPTH-entry trace RAM, optionally tagged with a cycle timestamp. It provides NUM_BRK address comparators with exact/range match and pass counts, and a post-trigger capture window that freezes the buffer around an event. The host debug port reaches all state through an 8-bit register bus clocked on CPUClock.

## Interface
- SAMPLE_W, 144, trace sample width in bits.
- DEPTH_LOG2, 7, log2 of trace depth; 1..8.
- NUM_BRK, 4, breakpoint channels; 1..8.
- TS_W, 36, timestamp width in bits.
- CPUClock  in  1  core clock; all logic on its rising edge.
- RESET_IN  in  1  synchronous, active-high reset.
- OP_FETCH  in  1  opcode fetch cycle.
- PC  in  16  program counter.
- INT_REQ  in  1  interrupt pending; suppresses breakpoint hits.
- MONITOR_REQUEST  in  1  monitor cycle active; suppresses hits and capture.
- BREAK_FLAG  in  1  CPU halted in break; suppresses capture and clears HW_BREAK_REQUEST.
- SAMPLE_IN  in  SAMPLE_W  data captured per qualified fetch.
- REG_WR / REG_RD  in  1  host write/read strobes, one cycle each.
- REG_ADDR  in  8  register address.
- REG_WDATA  in  8  write data.
- REG_RDATA  out  8  read data, registered.
- HW_BREAK_REQUEST  out  1  break request to the core.
- BRK_HIT  out  NUM_BRK  per-channel fire pulse, registered.
- TRACE_DONE  out  1  post-trigger window complete.
- REAL_TIME_ON  out  1  TRACE_CNTRL[7].

## Operation
- Register map:
  - 0x00 TRACE_CNTRL, reset 0x81. [0] TRACE_ON, [1] FLUSH (self-clearing), [2] TRIG_EN, [7] REAL_TIME_ON.
  - 0x01 READ_PNTR, R/W.
  - 0x02 WRITE_PNTR, RO.
  - 0x03 STATUS, RO: {5'b0, DONE, TRIGGERED, BUFF_FULL}.
  - 0x04 POST_CNT, R/W, reset 0.
  - 0x05 TRIG_PNTR, RO.
  - Channel k at 0x10+8k: +0 LO[15:8], +1 LO[7:0], +2 HI[15:8], +3 HI[7:0].
  - +4 CTRL: [0] EN, [1] RANGE, [2] BRK_ACT.
  - +5 PASS_CNT. All channel registers reset to 0.
  - 0x80+n: byte n of stored word at READ_PNTR, LSB first. Stored word = {SAMPLE_IN, timestamp}. Reading the highest byte auto-increments READ_PNTR (mod DEPTH).
  - Unmapped addresses read 0x00.
- Capture qualifier: OP_FETCH & TRACE_ON & ~FLUSH & ~BREAK_FLAG & ~MONITOR_REQUEST & ~DONE.
  - Each qualified fetch writes RAM[WRITE_PNTR]; WRITE_PNTR increments mod DEPTH.
  - A write at DEPTH-1 sets BUFF_FULL (sticky).
- Timestamp: zero until the first capture. It then increments every cycle and wraps mod 2^TS_W.
- Channel match:
  - RANGE=0: PC==LO. RANGE=1: LO<=PC<=HI, unsigned.
  - HI<LO never matches.
  - hit = EN & match & OP_FETCH & ~INT_REQ & ~MONITOR_REQUEST.
- Pass counter (8 bit): increments on each hit.
  - The channel fires on the hit where the count equals PASS_CNT (PASS_CNT=0 fires on the first hit).
  - After firing, the channel is spent until its CTRL is rewritten, which zeroes the counter.
- HW_BREAK_REQUEST sets on any fire with BRK_ACT=1. It holds until BREAK_FLAG=1, which clears it.
- Trigger: with TRIG_EN=1 and TRIGGERED=0, any fire sets TRIGGERED and latches WRITE_PNTR into TRIG_PNTR.
  - The triggering fetch's own capture counts as post-sample 0.
  - After POST_CNT further captures, DONE sets and capture stops.
  - TRACE_DONE mirrors DONE.
- FLUSH (write with [1]=1) or RESET_IN clears WRITE_PNTR, BUFF_FULL, TRIGGERED, DONE, TRIG_PNTR, timestamp and pass counters. RESET_IN additionally restores all registers.

## Timing
- Reset values: REG_RDATA 0x00, HW_BREAK_REQUEST 0, BRK_HIT 0, TRACE_DONE 0, REAL_TIME_ON 1.
- Register write takes effect at the edge of REG_WR. FLUSH reads back 0 one cycle later.
- REG_RDATA is valid the cycle after REG_RD and holds until the next REG_RD.
- Trace RAM read is synchronous: a byte read at 0x80+n reflects READ_PNTR as of the REG_RD cycle.
- BRK_HIT and HW_BREAK_REQUEST assert one cycle after the firing OP_FETCH. A sample is written at the edge ending the qualified fetch.
- Precedence:
  - RESET_IN > FLUSH > capture.
  - A host write to READ_PNTR beats auto-increment in the same cycle.
  - A CTRL write beats a simultaneous hit, so the counter is zeroed and the hit is discarded.
  - Multiple channels firing together: one trigger, one TRIG_PNTR.
  - Fire and BREAK_FLAG in the same cycle: the request is set.

## Configuration
- TRACE_TSTAMP_EN defined: the TS_W timestamp counter exists and is stored in the low TS_W bits of each word.
- Undefined: there is no counter, the stored word is SAMPLE_IN only, and byte indices shift accordingly (sample byte 0 at 0x80).

## Test plan
- Reset, read 0x00 -> 0x81.
  - Read 0x03 -> 0x00.
  - REAL_TIME_ON=1, HW_BREAK_REQUEST=0.
- 130 qualified fetches (DEPTH_LOG2=7) -> WRITE_PNTR=0x02, STATUS=0x01.
  - FLUSH then read 0x02 -> 0x00, 0x03 -> 0x00.
- Ch0 LO=0x1234, CTRL=0x05, PASS_CNT=2, fetch PC=0x1234 three times -> BRK_HIT[0] and HW_BREAK_REQUEST only after the third fetch.
  - Request clears when BREAK_FLAG=1.
- Ch1 range LO=0x0100 HI=0x01FF, CTRL=0x03 -> PC=0x01FF hits, PC=0x0200 does not.
  - INT_REQ=1 with PC=0x0150 does not hit.
- TRIG_EN, POST_CNT=3, trigger at WRITE_PNTR=0x10 -> TRIG_PNTR=0x10, DONE set, WRITE_PNTR freezes at 0x14.
- READ_PNTR=5, read all bytes of the word -> READ_PNTR=6.
  - Timestamp bytes show the increasing cycle count (TRACE_TSTAMP_EN); SAMPLE_IN bytes match what was driven.

Source files
------------

// File: rtl/debug_trace_ctl.sv
// debug_trace_ctl: opcode-fetch trace buffer with address breakpoints and a post-trigger capture window.
// Define TRACE_TSTAMP_EN to store a cycle timestamp in the low TS_W bits of every trace word.
module debug_trace_ctl #(
  parameter int SAMPLE_W   = 144,
  parameter int DEPTH_LOG2 = 7,
  parameter int NUM_BRK    = 4,
  parameter int TS_W       = 36
) (
  input  logic                CPUClock,
  input  logic                RESET_IN,
  input  logic                OP_FETCH,
  input  logic [15:0]         PC,
  input  logic                INT_REQ,
  input  logic                MONITOR_REQUEST,
  input  logic                BREAK_FLAG,
  input  logic [SAMPLE_W-1:0] SAMPLE_IN,
  input  logic                REG_WR,
  input  logic                REG_RD,
  input  logic [7:0]          REG_ADDR,
  input  logic [7:0]          REG_WDATA,
  output logic [7:0]          REG_RDATA,
  output logic                HW_BREAK_REQUEST,
  output logic [NUM_BRK-1:0]  BRK_HIT,
  output logic                TRACE_DONE,
  output logic                REAL_TIME_ON
);
`ifdef TRACE_TSTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int WORD_W = SAMPLE_W + (TS_EN ? TS_W : 0);
  localparam int NB     = (WORD_W + 7) / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  logic [7:0]            r_ctrl, r_post, r_rdata, r_pcnt;
  logic [DEPTH_LOG2-1:0] r_rd_ptr, r_wr_ptr, r_trig_ptr;
  logic                  r_full, r_trig, r_done, r_hwbrk;
  logic [NUM_BRK-1:0]    r_brk_hit, r_spent;
  logic [15:0]           r_lo   [NUM_BRK];
  logic [15:0]           r_hi   [NUM_BRK];
  logic [2:0]            r_cctl [NUM_BRK];
  logic [7:0]            r_pass [NUM_BRK];
  logic [7:0]            r_cnt  [NUM_BRK];
  logic [WORD_W-1:0]     r_mem  [DEPTH];
  logic [WORD_W-1:0]     w_word;
  logic                  w_flush, w_cap, w_trig, w_rd_last;
  logic [NUM_BRK-1:0]    w_hit, w_fire, w_ctl_wr, w_act;
  logic [7:0]            w_rd, w_byte;

  assign w_flush   = r_ctrl[1];
  assign w_cap     = OP_FETCH & r_ctrl[0] & ~w_flush & ~BREAK_FLAG & ~MONITOR_REQUEST & ~r_done & ~RESET_IN;
  assign w_trig    = r_ctrl[2] & ~r_trig & (|w_fire);
  assign w_rd_last = REG_RD & (REG_ADDR == 8'(128 + NB - 1));
  assign w_byte    = 8'((NB * 8)'(r_mem[r_rd_ptr]) >> {REG_ADDR[6:0], 3'b000});

`ifdef TRACE_TSTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic            r_ts_run;
  // Counter idles at zero until the first capture so stored stamps are relative to it.
  always_ff @(posedge CPUClock) begin
    if (RESET_IN || w_flush) begin
      r_ts     <= '0;
      r_ts_run <= 1'b0;
    end else if (r_ts_run || w_cap) begin
      r_ts     <= r_ts + 1'b1;
      r_ts_run <= 1'b1;
    end
  end
  assign w_word = {SAMPLE_IN, r_ts};
`else
  assign w_word = SAMPLE_IN;
`endif

  always_comb begin
    w_hit    = '0;
    w_fire   = '0;
    w_ctl_wr = '0;
    w_act    = '0;
    for (int k = 0; k < NUM_BRK; k++) begin
      w_ctl_wr[k] = REG_WR & (REG_ADDR == 8'(20 + 8 * k));
      w_act[k]    = r_cctl[k][2];
      w_hit[k]    = r_cctl[k][0] & OP_FETCH & ~INT_REQ & ~MONITOR_REQUEST & ~w_ctl_wr[k] &
                    (r_cctl[k][1] ? (PC >= r_lo[k] && PC <= r_hi[k]) : (PC == r_lo[k]));
      w_fire[k]   = w_hit[k] & ~r_spent[k] & (r_cnt[k] == r_pass[k]);
    end
  end

  always_comb begin
    w_rd = 8'h00;
    case (REG_ADDR)
      8'h00:   w_rd = r_ctrl;
      8'h01:   w_rd = 8'(r_rd_ptr);
      8'h02:   w_rd = 8'(r_wr_ptr);
      8'h03:   w_rd = {5'b0, r_done, r_trig, r_full};
      8'h04:   w_rd = r_post;
      8'h05:   w_rd = 8'(r_trig_ptr);
      default: w_rd = 8'h00;
    endcase
    for (int k = 0; k < NUM_BRK; k++)
      if (REG_ADDR[7:3] == 5'(k + 2))
        w_rd = REG_ADDR[2:0] == 3'd0 ? r_lo[k][15:8] :
               REG_ADDR[2:0] == 3'd1 ? r_lo[k][7:0]  :
               REG_ADDR[2:0] == 3'd2 ? r_hi[k][15:8] :
               REG_ADDR[2:0] == 3'd3 ? r_hi[k][7:0]  :
               REG_ADDR[2:0] == 3'd4 ? {5'b0, r_cctl[k]} :
               REG_ADDR[2:0] == 3'd5 ? r_pass[k] : 8'h00;
    if (REG_ADDR[7] && REG_ADDR[6:0] < 7'(NB))
      w_rd = w_byte;
  end

  always_ff @(posedge CPUClock)
    if (w_cap) r_mem[r_wr_ptr] <= w_word;

  always_ff @(posedge CPUClock) begin
    if (RESET_IN) begin
      r_ctrl     <= 8'h81;
      r_post     <= '0;
      r_rdata    <= '0;
      r_pcnt     <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_trig_ptr <= '0;
      r_full     <= 1'b0;
      r_trig     <= 1'b0;
      r_done     <= 1'b0;
      r_hwbrk    <= 1'b0;
      r_brk_hit  <= '0;
      r_spent    <= '0;
      for (int k = 0; k < NUM_BRK; k++) begin
        r_lo[k]   <= '0;
        r_hi[k]   <= '0;
        r_cctl[k] <= '0;
        r_pass[k] <= '0;
        r_cnt[k]  <= '0;
      end
    end else begin
      r_ctrl <= (REG_WR && REG_ADDR == 8'h00) ? REG_WDATA : {r_ctrl[7:2], 1'b0, r_ctrl[0]};
      if (REG_WR && REG_ADDR == 8'h01) r_rd_ptr <= REG_WDATA[DEPTH_LOG2-1:0];
      else if (w_rd_last) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (REG_WR && REG_ADDR == 8'h04) r_post <= REG_WDATA;
      if (REG_RD) r_rdata <= w_rd;
      r_brk_hit <= w_fire;
      if (|(w_fire & w_act)) r_hwbrk <= 1'b1;
      else if (BREAK_FLAG) r_hwbrk <= 1'b0;
      for (int k = 0; k < NUM_BRK; k++) begin
        if (REG_WR && REG_ADDR == 8'(16 + 8 * k)) r_lo[k][15:8] <= REG_WDATA;
        if (REG_WR && REG_ADDR == 8'(17 + 8 * k)) r_lo[k][7:0]  <= REG_WDATA;
        if (REG_WR && REG_ADDR == 8'(18 + 8 * k)) r_hi[k][15:8] <= REG_WDATA;
        if (REG_WR && REG_ADDR == 8'(19 + 8 * k)) r_hi[k][7:0]  <= REG_WDATA;
        if (REG_WR && REG_ADDR == 8'(21 + 8 * k)) r_pass[k]     <= REG_WDATA;
        if (w_ctl_wr[k]) begin
          r_cctl[k]  <= REG_WDATA[2:0];
          r_cnt[k]   <= '0;
          r_spent[k] <= 1'b0;
        end else if (w_hit[k] && !r_spent[k]) begin
          r_cnt[k]   <= r_cnt[k] + 1'b1;
          r_spent[k] <= w_fire[k];
        end
      end
      if (w_cap) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (&r_wr_ptr) r_full <= 1'b1;
      end
      // The triggering fetch itself is post-sample 0.
      if (w_trig) begin
        r_trig     <= 1'b1;
        r_trig_ptr <= r_wr_ptr;
        r_pcnt     <= '0;
        r_done     <= (r_post == 8'd0);
      end else if (r_trig && w_cap) begin
        r_pcnt <= r_pcnt + 1'b1;
        if (r_pcnt + 8'd1 == r_post) r_done <= 1'b1;
      end
      if (w_flush) begin
        r_wr_ptr   <= '0;
        r_full     <= 1'b0;
        r_trig     <= 1'b0;
        r_done     <= 1'b0;
        r_trig_ptr <= '0;
        r_pcnt     <= '0;
        r_spent    <= '0;
        for (int k = 0; k < NUM_BRK; k++) r_cnt[k] <= '0;
      end
    end
  end

  assign REG_RDATA        = r_rdata;
  assign HW_BREAK_REQUEST = r_hwbrk;
  assign BRK_HIT          = r_brk_hit;
  assign TRACE_DONE       = r_done;
  assign REAL_TIME_ON     = r_ctrl[7];
endmodule
